// File: rtl/sdram_cmd_frontend_if.sv
// Host command/response and SDRAM controller request bundle for sdram_cmd_frontend.
// slave = front-end view, master = host + controller view.
interface sdram_cmd_frontend_if #(
  parameter int unsigned HADDR_WIDTH = 24
) ();
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_we;
  logic [HADDR_WIDTH-1:0] cmd_addr;
  logic [15:0]            cmd_wdata;
  logic                   resp_valid;
  logic [15:0]            resp_data;
  logic [HADDR_WIDTH-1:0] ctl_wr_addr;
  logic [HADDR_WIDTH-1:0] ctl_rd_addr;
  logic [15:0]            ctl_wr_data;
  logic                   ctl_wr_enable;
  logic                   ctl_rd_enable;
  logic [15:0]            ctl_rd_data;
  logic                   ctl_rd_ready;
  logic                   ctl_busy;
  logic                   idle;
  logic                   err_timeout;
  logic [15:0]            rd_count;
  logic [15:0]            wr_count;

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, ctl_rd_data, ctl_rd_ready, ctl_busy,
    output cmd_ready, resp_valid, resp_data, ctl_wr_addr, ctl_rd_addr, ctl_wr_data,
           ctl_wr_enable, ctl_rd_enable, idle, err_timeout, rd_count, wr_count
  );

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, ctl_rd_data, ctl_rd_ready, ctl_busy,
    input  cmd_ready, resp_valid, resp_data, ctl_wr_addr, ctl_rd_addr, ctl_wr_data,
           ctl_wr_enable, ctl_rd_enable, idle, err_timeout, rd_count, wr_count
  );
endinterface

// File: rtl/sdram_cmd_frontend.sv
// Buffers host read/write commands and issues them one at a time to the SDRAM controller.
// Optional completed-transaction counters are built when SDRAM_FRONTEND_STATS_EN is defined.
module sdram_cmd_frontend #(
  parameter int unsigned HADDR_WIDTH = 24,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input logic                 clk,
  input logic                 rst_n,
  sdram_cmd_frontend_if.slave bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = 1 + HADDR_WIDTH + 16;
  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW:0] FullCnt = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] TimeoutCnt = CW'(ACK_TIMEOUT);
  localparam logic [CW-1:0] TimeoutPre = CW'(ACK_TIMEOUT - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StGap   = 2'd3;

  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [AW:0]            wptr_q, wptr_d, rptr_q, rptr_d, occ_d;
  logic                   push, pop;
  logic [EW-1:0]          head;
  logic [1:0]             state_q, state_d;
  logic                   we_q, we_d;
  logic                   wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [HADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]            wdata_q, wdata_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [15:0]            resp_data_q, resp_data_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   idle_q, idle_d;

  assign push   = bus.cmd_valid & cmd_ready_q;
  assign head   = mem_q[rptr_q[AW-1:0]];
  assign wptr_d = wptr_q + (AW + 1)'(push);
  assign rptr_d = rptr_q + (AW + 1)'(pop);
  assign occ_d  = wptr_d - rptr_d;

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= {bus.cmd_we, bus.cmd_addr, bus.cmd_wdata};
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    wr_en_d      = wr_en_q;
    rd_en_d      = rd_en_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    pop          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wptr_q != rptr_q) begin
          state_d                 = StIssue;
          {we_d, addr_d, wdata_d} = head;
          wr_en_d                 = head[EW-1];
          rd_en_d                 = ~head[EW-1];
          cnt_d                   = '0;
        end
      end
      StIssue: begin
        // The enable is never withdrawn without busy; a timeout only flags the stall.
        if (bus.ctl_busy) begin
          wr_en_d = 1'b0;
          rd_en_d = 1'b0;
          state_d = StWait;
        end else if (cnt_q != TimeoutCnt) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == TimeoutPre) err_d = 1'b1;
        end
      end
      StWait: begin
        if (bus.ctl_rd_ready && !we_q) begin
          resp_valid_d = 1'b1;
          resp_data_d  = bus.ctl_rd_data;
        end
        if (!bus.ctl_busy) begin
          pop     = 1'b1;
          state_d = StGap;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    cmd_ready_d = (occ_d != FullCnt);
    idle_d      = (state_d == StIdle) && (wptr_d == rptr_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      state_q      <= StIdle;
      we_q         <= 1'b0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      cmd_ready_q  <= 1'b1;
      idle_q       <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      state_q      <= state_d;
      we_q         <= we_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      cmd_ready_q  <= cmd_ready_d;
      idle_q       <= idle_d;
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.ctl_wr_addr   = addr_q;
  assign bus.ctl_rd_addr   = addr_q;
  assign bus.ctl_wr_data   = wdata_q;
  assign bus.ctl_wr_enable = wr_en_q;
  assign bus.ctl_rd_enable = rd_en_q;
  assign bus.idle          = idle_q;
  assign bus.err_timeout   = err_q;

`ifdef SDRAM_FRONTEND_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (pop) begin
      if (we_q) wr_cnt_q <= wr_cnt_q + 16'd1;
      else      rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

  assign bus.rd_count = rd_cnt_q;
  assign bus.wr_count = wr_cnt_q;
`else
  assign bus.rd_count = '0;
  assign bus.wr_count = '0;
`endif
endmodule

// File: tb/tb_sdram_cmd_frontend.sv
// Directed bench for sdram_cmd_frontend: a bench-side controller model answers each issued
// enable; a second instance with ACK_TIMEOUT=15 covers the timeout flag.
module tb_sdram_cmd_frontend;
`ifdef SDRAM_FRONTEND_STATS_EN
  localparam int StatsEn = 1;
`else
  localparam int StatsEn = 0;
`endif

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  sdram_cmd_frontend_if #(.HADDR_WIDTH(24)) bus ();
  sdram_cmd_frontend_if #(.HADDR_WIDTH(24)) bus_to ();

  sdram_cmd_frontend #(.HADDR_WIDTH(24), .FIFO_DEPTH(4), .ACK_TIMEOUT(1023)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  sdram_cmd_frontend #(.HADDR_WIDTH(24), .FIFO_DEPTH(4), .ACK_TIMEOUT(15)) dut_to (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=still running exp=finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_cmd_ready", bus.cmd_ready, 1);
    check_eq("rst_resp_valid", bus.resp_valid, 0);
    check_eq("rst_resp_data", bus.resp_data, 0);
    check_eq("rst_wr_en", bus.ctl_wr_enable, 0);
    check_eq("rst_rd_en", bus.ctl_rd_enable, 0);
    check_eq("rst_wr_addr", bus.ctl_wr_addr, 0);
    check_eq("rst_rd_addr", bus.ctl_rd_addr, 0);
    check_eq("rst_wr_data", bus.ctl_wr_data, 0);
    check_eq("rst_idle", bus.idle, 0);
    check_eq("rst_err", bus.err_timeout, 0);
    check_eq("rst_rd_count", bus.rd_count, 0);
    check_eq("rst_wr_count", bus.wr_count, 0);
  endtask

  task automatic push_cmd(input logic we, input logic [23:0] addr, input logic [15:0] wdata);
    int wait_n;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    wait_n = 0;
    while (!bus.cmd_ready && wait_n < 200) begin
      wait_n++;
      tick();
    end
    check_eq("push_ready", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Controller model for one command: busy rises `stall` cycles after the enable is seen, stays
  // high busy_len cycles, and (if rdy) pulses rd_ready in its last busy cycle.
  task automatic serve(input logic we, input logic [23:0] addr, input logic [15:0] wdata,
                       input int stall, input int busy_len, input logic rdy,
                       input logic [15:0] rdata);
    int   gap;
    logic en;
    logic pend;
    gap = 0;
    en  = we ? bus.ctl_wr_enable : bus.ctl_rd_enable;
    while (!en && gap < 100) begin
      gap++;
      tick();
      en = we ? bus.ctl_wr_enable : bus.ctl_rd_enable;
    end
    check_eq("en_seen", en, 1);
    if (!en) return;
    check_eq("gap_before_en", (gap >= 1), 1);
    check_eq("en_exclusive", we ? bus.ctl_rd_enable : bus.ctl_wr_enable, 0);
    check_eq("issue_wr_addr", bus.ctl_wr_addr, addr);
    check_eq("issue_rd_addr", bus.ctl_rd_addr, addr);
    if (we) check_eq("issue_wr_data", bus.ctl_wr_data, wdata);
    for (int i = 0; i < stall; i++) begin
      tick();
      check_eq("hold_en", we ? bus.ctl_wr_enable : bus.ctl_rd_enable, 1);
      check_eq("hold_addr", bus.ctl_wr_addr, addr);
    end
    bus.ctl_busy = 1'b1;
    pend = 1'b0;
    for (int i = 1; i <= busy_len; i++) begin
      tick();
      check_eq("en_dropped", bus.ctl_wr_enable | bus.ctl_rd_enable, 0);
      check_eq("resp_valid", bus.resp_valid, pend);
      if (pend) check_eq("resp_data", bus.resp_data, rdata);
      pend = 1'b0;
      bus.ctl_rd_ready = 1'b0;
      if (i == busy_len - 1 && rdy) begin
        bus.ctl_rd_ready = 1'b1;
        bus.ctl_rd_data  = rdata;
        pend             = !we;
      end
      if (i == busy_len) bus.ctl_busy = 1'b0;
    end
    tick();
    check_eq("resp_once", bus.resp_valid, 0);
    check_eq("gap_no_en", bus.ctl_wr_enable | bus.ctl_rd_enable, 0);
  endtask

  logic        b2b_we    [5];
  logic [23:0] b2b_addr  [5];
  logic [15:0] b2b_wdata [5];

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    bus.cmd_valid = 0; bus.cmd_we = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0;
    bus.ctl_rd_data = 0; bus.ctl_rd_ready = 0; bus.ctl_busy = 0;
    bus_to.cmd_valid = 0; bus_to.cmd_we = 0; bus_to.cmd_addr = 0; bus_to.cmd_wdata = 0;
    bus_to.ctl_rd_data = 0; bus_to.ctl_rd_ready = 0; bus_to.ctl_busy = 0;
    b2b_we    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    b2b_addr  = '{24'h100001, 24'h200002, 24'h300003, 24'h400004, 24'h500005};
    b2b_wdata = '{16'hA001, 16'h0000, 16'hA003, 16'h0000, 16'hA005};

    #22;
    check_reset_outputs();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("idle_after_rst", bus.idle, 1);

    // Single write; rd_ready during the write must not produce a response.
    push_cmd(1'b1, 24'h012345, 16'hBEEF);
    check_eq("idle_drops", bus.idle, 0);
    serve(1'b1, 24'h012345, 16'hBEEF, 2, 6, 1'b1, 16'h1111);
    check_eq("wr_count_1", bus.wr_count, 1 * StatsEn);

    // Single read.
    push_cmd(1'b0, 24'h00ABCD, 16'h0);
    serve(1'b0, 24'h00ABCD, 16'h0, 2, 4, 1'b1, 16'h5A5A);
    check_eq("rd_count_1", bus.rd_count, 1 * StatsEn);
    tick();
    tick();
    check_eq("resp_data_hold", bus.resp_data, 16'h5A5A);
    check_eq("idle_again", bus.idle, 1);

    // Refresh stall: no busy for 40 cycles.
    push_cmd(1'b1, 24'h3C0F00, 16'h1234);
    serve(1'b1, 24'h3C0F00, 16'h1234, 40, 3, 1'b0, 16'h0);
    check_eq("stall_no_err", bus.err_timeout, 0);
    check_eq("wr_count_2", bus.wr_count, 2 * StatsEn);

    // Back-to-back: 5 pushes every cycle into a 4-deep FIFO.
    fork
      begin
        int wait_n;
        for (int i = 0; i < 5; i++) begin
          bus.cmd_valid = 1'b1;
          bus.cmd_we    = b2b_we[i];
          bus.cmd_addr  = b2b_addr[i];
          bus.cmd_wdata = b2b_wdata[i];
          check_eq($sformatf("b2b_ready_%0d", i), bus.cmd_ready, (i < 4) ? 1 : 0);
          wait_n = 0;
          while (!bus.cmd_ready && wait_n < 300) begin
            wait_n++;
            tick();
          end
          check_eq("b2b_push_ok", bus.cmd_ready, 1);
          tick();
        end
        bus.cmd_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 5; i++)
          serve(b2b_we[i], b2b_addr[i], b2b_wdata[i], 1, 2, 1'b1, 16'hC000 + 16'(i));
      end
    join
    check_eq("wr_count_5", bus.wr_count, 5 * StatsEn);
    check_eq("rd_count_3", bus.rd_count, 3 * StatsEn);

    // Reset while a read sits in WAIT_DONE with two more queued.
    tick();
    tick();
    push_cmd(1'b0, 24'h0A0001, 16'h0);
    push_cmd(1'b0, 24'h0A0002, 16'h0);
    push_cmd(1'b0, 24'h0A0003, 16'h0);
    check_eq("mr_rd_en", bus.ctl_rd_enable, 1);
    bus.ctl_busy = 1'b1;
    tick();
    check_eq("mr_wait", bus.ctl_rd_enable, 0);
    bus.ctl_rd_ready = 1'b1;
    bus.ctl_rd_data  = 16'hDEAD;
    rst_n            = 1'b0;
    #1;
    check_reset_outputs();
    bus.ctl_busy     = 1'b0;
    bus.ctl_rd_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("mr_idle", bus.idle, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("mr_no_en", bus.ctl_wr_enable | bus.ctl_rd_enable, 0);
      check_eq("mr_no_resp", bus.resp_valid, 0);
    end

    // Timeout on the ACK_TIMEOUT=15 instance: busy never comes.
    bus_to.cmd_valid = 1'b1;
    bus_to.cmd_we    = 1'b1;
    bus_to.cmd_addr  = 24'h777777;
    bus_to.cmd_wdata = 16'h7777;
    tick();
    bus_to.cmd_valid = 1'b0;
    tick();
    check_eq("to_en", bus_to.ctl_wr_enable, 1);
    check_eq("to_err_start", bus_to.err_timeout, 0);
    repeat (14) tick();
    check_eq("to_err_before", bus_to.err_timeout, 0);
    tick();
    check_eq("to_err_set", bus_to.err_timeout, 1);
    repeat (10) tick();
    check_eq("to_err_sticky", bus_to.err_timeout, 1);
    check_eq("to_en_held", bus_to.ctl_wr_enable, 1);
    check_eq("to_addr_held", bus_to.ctl_wr_addr, 24'h777777);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
